branch_ctrl: RTL

//  EX-stage branch/jump controller wrapped around the branch comparator datapath. Accepts one

---
 rtl/branch_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/branch_ctrl.sv
// EX-stage branch/jump controller: resolves the branch condition and target, then
// sequences the front-end redirect pulse, the flush window and the branch statistics.
module branch_ctrl #(
  parameter int XLEN         = 64,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             ex_valid_i,
  output logic             ex_ready_o,
  input  logic [XLEN-1:0]  ex_pc_i,
  input  logic [XLEN-1:0]  ex_imm_i,
  input  logic [XLEN-1:0]  ex_rs1_i,
  input  logic [XLEN-1:0]  ex_rs2_i,
  input  logic [2:0]       ex_cmp_op_i,
  input  logic             ex_is_jal_i,
  input  logic             ex_is_jalr_i,
  output logic             redirect_valid_o,
  output logic [XLEN-1:0]  redirect_pc_o,
  output logic             flush_o,
  output logic             misalign_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] taken_cnt_o
);

  // Handshake: a candidate transfers on a rising edge where ex_valid_i && ex_ready_o;
  // operands are sampled only at that edge, and ex_valid_i is ignored while ex_ready_o is low.

  localparam logic [2:0] CMP_NO  = 3'd0;
  localparam logic [2:0] CMP_EQ  = 3'd1;
  localparam logic [2:0] CMP_NE  = 3'd2;
  localparam logic [2:0] CMP_LT  = 3'd3;
  localparam logic [2:0] CMP_GE  = 3'd4;
  localparam logic [2:0] CMP_LTU = 3'd5;
  localparam logic [2:0] CMP_GEU = 3'd6;

  // The flush counter tracks the FLUSH-state cycles that follow the redirect cycle.
  localparam int FC_W = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES - 1) : 1;
  localparam logic [FC_W-1:0] FLUSH_LAST =
    FC_W'((FLUSH_CYCLES > 1) ? (FLUSH_CYCLES - 2) : 0);
  localparam logic [XLEN-1:0] JALR_MASK = {{(XLEN-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REDIRECT = 2'd1,
    S_FLUSH    = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [FC_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
  logic             misalign_q, misalign_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

  logic             accept;
  logic             is_jump;
  logic             is_cond;
  logic             op_eq, op_lt, op_ltu;
  logic             cond_taken;
  logic             taken;
  logic [XLEN-1:0]  target;
  logic             misaligned;

  // Comparator datapath and target adder
  always_comb begin
    accept  = ex_valid_i && (state_q == S_IDLE);
    is_jump = ex_is_jal_i || ex_is_jalr_i;
    op_eq   = (ex_rs1_i == ex_rs2_i);
    op_lt   = ($signed(ex_rs1_i) < $signed(ex_rs2_i));
    op_ltu  = (ex_rs1_i < ex_rs2_i);

    cond_taken = 1'b0;
    is_cond    = 1'b0;
    case (ex_cmp_op_i)
      CMP_EQ:  begin cond_taken = op_eq;   is_cond = 1'b1; end
      CMP_NE:  begin cond_taken = !op_eq;  is_cond = 1'b1; end
      CMP_LT:  begin cond_taken = op_lt;   is_cond = 1'b1; end
      CMP_GE:  begin cond_taken = !op_lt;  is_cond = 1'b1; end
      CMP_LTU: begin cond_taken = op_ltu;  is_cond = 1'b1; end
      CMP_GEU: begin cond_taken = !op_ltu; is_cond = 1'b1; end
      CMP_NO:  begin cond_taken = 1'b0;    is_cond = 1'b0; end
      default: begin cond_taken = 1'b0;    is_cond = 1'b0; end
    endcase
    if (is_jump) begin
      is_cond = 1'b0;
    end

    taken = is_jump || cond_taken;

    if (ex_is_jalr_i) begin
      target = (ex_rs1_i + ex_imm_i) & JALR_MASK;
    end else begin
      target = ex_pc_i + ex_imm_i;
    end
    misaligned = (target[1:0] != 2'b00);
  end

  // FSM next state
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept && taken && !misaligned) begin
          state_d = S_REDIRECT;
        end
      end
      S_REDIRECT: begin
        flush_cnt_d = '0;
        state_d     = (FLUSH_CYCLES > 1) ? S_FLUSH : S_IDLE;
      end
      S_FLUSH: begin
        if (flush_cnt_q == FLUSH_LAST) begin
          state_d = S_IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Redirect target, misalign pulse and statistics
  always_comb begin
    redirect_pc_d = redirect_pc_q;
    misalign_d    = 1'b0;
    branch_cnt_d  = branch_cnt_q;
    taken_cnt_d   = taken_cnt_q;
    if (accept) begin
      if (taken && !misaligned) begin
        redirect_pc_d = target;
      end
      misalign_d = taken && misaligned;
      if (is_cond) begin
        branch_cnt_d = branch_cnt_q + 1'b1;
        if (cond_taken) begin
          taken_cnt_d = taken_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= S_IDLE;
      flush_cnt_q   <= '0;
      redirect_pc_q <= '0;
      misalign_q    <= 1'b0;
      branch_cnt_q  <= '0;
      taken_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      redirect_pc_q <= redirect_pc_d;
      misalign_q    <= misalign_d;
      branch_cnt_q  <= branch_cnt_d;
      taken_cnt_q   <= taken_cnt_d;
    end
  end

  always_comb begin
    ex_ready_o       = (state_q == S_IDLE);
    redirect_valid_o = (state_q == S_REDIRECT);
    flush_o          = (state_q != S_IDLE);
    redirect_pc_o    = redirect_pc_q;
    misalign_o       = misalign_q;
    branch_cnt_o     = branch_cnt_q;
    taken_cnt_o      = taken_cnt_q;
  end

endmodule
